apb_slave_regs: RTL and testbench
=================================

Name: apb_slave_regs

Overview:
APB completer (slave) terminating one `apb_if` segment. It drives rdata, ready and the slave error response back to the APB master. It implements a bank of REG_NUM memory-mapped DATA_WIDTH registers with programmable wait states, byte strobes, and error response on illegal accesses. It is the reusable responder model for the master testbench and a synthesizable peripheral register front-end.

Parameters:
ADDR_WIDTH, 32, width of addr
DATA_WIDTH, 32, width of wdata/rdata; must be 8, 16 or 32
REG_NUM, 16, number of registers, word-addressed from BASE_ADDR
BASE_ADDR, 0, byte address of register 0
WAIT_CYCLES, 0, ready-low cycles inserted in every access phase (0..15)

Ports:
clk  input  1  APB clock
rstn  input  1  asynchronous active-low reset
sel  input  1  PSEL for this slave
penable  input  1  PENABLE
write  input  1  1 = write, 0 = read
addr  input  ADDR_WIDTH  byte address
wdata  input  DATA_WIDTH  write data
strb  input  DATA_WIDTH/8  byte write strobes
prot  input  3  PPROT; bit0 = privileged
rdata  output  DATA_WIDTH  read data, valid only while ready=1 on a read
ready  output  1  PREADY
slave_error  output  1  PSLVERR, valid only while ready=1

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rstn).
- Reset values:
  - All registers 0; FSM = IDLE; wait counter 0.
  - ready, slave_error and rdata are 0.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when sel=1 && penable=0.
  - SETUP -> ACCESS on the next edge. The wait counter is loaded with WAIT_CYCLES.
  - In ACCESS, the counter decrements each cycle while nonzero.
- ready = (state==ACCESS) && sel && penable && (counter==0). It is combinational from registered state.
  - WAIT_CYCLES=0: ready is high in the first access cycle, i.e. the second cycle of the transfer.
  - WAIT_CYCLES=N: ready is high in access cycle N+1.
- Completion happens on the clk edge where ready=1:
  - Write: register[idx] byte lane i is updated when strb[i]=1; other lanes hold.
  - Read: rdata = register[idx] combinationally during the ready cycle; rdata = 0 otherwise.
- After completion:
  - sel=1 && penable=0 (back-to-back transfer) -> SETUP.
  - Otherwise -> IDLE.
- Error conditions (checked on the address/controls sampled in SETUP):
  - addr < BASE_ADDR, or idx >= REG_NUM where idx = (addr-BASE_ADDR)/(DATA_WIDTH/8).
  - addr not aligned to DATA_WIDTH/8.
  - Write to register 0 with prot[0]=0 (register 0 is privileged-write-only).
- Error response:
  - slave_error=1 together with ready.
  - No register is modified; rdata = 0.
  - Wait states still apply.
- Address/control are captured in SETUP. Changes to the inputs during ACCESS do not alter the target index or the error decision. wdata/strb are sampled at the completion edge.
- Protocol violations:
  - sel drops during ACCESS before ready -> abort to IDLE, no write, no response.
  - penable=1 seen in IDLE -> ignored (remain IDLE).
- Read-only view: strb is ignored on reads.
- Reset mid-transfer: immediate return to reset values and the transfer is lost. The master must restart.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to addr 0x4 (strb=0xF), then read 0x4 -> ready high in the second cycle of each transfer; rdata=0xDEADBEEF; slave_error=0.
- Partial strobe: register 0x8 = 0x11223344; write 0xAABBCCDD with strb=0b0101 -> readback 0x11BB33DD.
- WAIT_CYCLES=3: a single read -> exactly 3 access cycles with ready=0, then ready=1 in the 4th access cycle; counter reloads for a back-to-back second transfer with no intervening IDLE.
- Errors: read addr 0x40 with REG_NUM=16 -> slave_error=1, rdata=0; write addr 0x6 (unaligned) -> slave_error=1, memory unchanged; write reg 0 with prot=3'b000 -> error, with prot=3'b001 -> OK.
- Abort: WAIT_CYCLES=2, write starts, sel deasserted after 1 access cycle -> no ready pulse; target register unchanged; FSM returns to IDLE.
- Reset: assert rstn=0 asynchronously mid-ACCESS -> ready/slave_error/rdata go to 0 immediately; all registers read 0 afterwards.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB completer with a bank of REG_NUM word registers, programmable wait states,
// byte strobes and PSLVERR on out-of-range, misaligned or unprivileged accesses.
module apb_slave_regs #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    REG_NUM     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sel,
  input  logic                    penable,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [2:0]              prot,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    slave_error
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int ALIGN  = $clog2(NBYTES);
  localparam int IDXW   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT  = ADDR_WIDTH'(REG_NUM);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e          state_q, state_d, phase;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic            write_q, write_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

  logic [ADDR_WIDTH-1:0] offset, word;
  logic below, misaligned, out_of_range, priv_viol, do_write;
  logic unused_prot;

  assign offset       = addr - BASE_ADDR;
  assign word         = offset >> ALIGN;
  assign below        = addr < BASE_ADDR;
  assign misaligned   = (addr & ALIGN_MASK) != '0;
  assign out_of_range = word >= REG_LIMIT;
  assign priv_viol    = write && (word == '0) && !prot[0];
  assign unused_prot  = ^prot[2:1];

  // SETUP is the cycle the master presents sel && !penable; it is decoded from the
  // live bus so the registered state can already be ACCESS in the second cycle.
  always_comb begin
    phase   = IDLE;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    write_d = write_q;
    ready   = 1'b0;
    if (state_q == ACCESS) begin
      phase = ACCESS;
    end else if (sel && !penable) begin
      phase = SETUP;
    end
    case (phase)
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYCLES);
        idx_d   = IDXW'(word);
        err_d   = below || misaligned || out_of_range || priv_viol;
        write_d = write;
      end
      ACCESS: begin
        ready = sel && penable && (cnt_q == '0);
        if (!sel || ready) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign do_write    = ready && write_q && !err_q;
  assign slave_error = ready && err_q;
  assign rdata       = (ready && !write_q && !err_q) ? regs_q[idx_q] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      write_q <= write_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (do_write) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (strb[b]) begin
          regs_q[idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Randomized bench for apb_slave_regs: two instances (no wait states at base 0,
// three wait states at base 0x100) checked every cycle against a transfer-level model.
module tb_apb_slave_regs;
  localparam int RN = 16;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0]       sel, pen, wr;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  strb;
  logic [1:0][2:0]  prot;
  logic [1:0][31:0] rdata;
  logic [1:0]       ready, serr;

  logic [1:0]       exp_ready, exp_err;
  logic [1:0][31:0] exp_rdata;
  logic [31:0]      mem [2][RN];

  int checks = 0;
  int errors = 0;

  apb_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(RN),
                   .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rstn(rstn), .sel(sel[0]), .penable(pen[0]), .write(wr[0]),
    .addr(addr[0]), .wdata(wdata[0]), .strb(strb[0]), .prot(prot[0]),
    .rdata(rdata[0]), .ready(ready[0]), .slave_error(serr[0]));

  apb_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(RN),
                   .BASE_ADDR(32'h100), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rstn(rstn), .sel(sel[1]), .penable(pen[1]), .write(wr[1]),
    .addr(addr[1]), .wdata(wdata[1]), .strb(strb[1]), .prot(prot[1]),
    .rdata(rdata[1]), .ready(ready[1]), .slave_error(serr[1]));

  function automatic int wait_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h100 : 32'h0;
  endfunction

  function automatic bit model_err(input int k, input logic [31:0] a, input bit w, input logic [2:0] p);
    if (a < base_of(k)) return 1'b1;
    if (a % NB != 0) return 1'b1;
    if ((a - base_of(k)) / NB >= RN) return 1'b1;
    if (w && (a - base_of(k)) / NB == 0 && !p[0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ready%0d", k), 32'(ready[k]), 32'(exp_ready[k]));
      check($sformatf("slverr%0d", k), 32'(serr[k]), 32'(exp_err[k]));
      check($sformatf("rdata%0d", k), rdata[k], exp_rdata[k]);
    end
  end

  task automatic clear_exp(input int k);
    exp_ready[k] = 1'b0;
    exp_err[k]   = 1'b0;
    exp_rdata[k] = '0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 2; k++) begin
        sel[k] = 1'($urandom);
        pen[k] = 1'b1;
        clear_exp(k);
      end
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    sel = '0;
    pen = '0;
  endtask

  // abort_at < 0: normal transfer; otherwise sel drops in access cycle abort_at+1.
  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] p, input int abort_at,
                      output logic [31:0] rd, output bit er, output int lat);
    bit e;
    int idx;
    int nacc;
    e    = model_err(k, a, w, p);
    idx  = e ? 0 : int'((a - base_of(k)) / NB);
    nacc = wait_of(k) + 1;
    rd   = '0;
    er   = 1'b0;
    lat  = 0;
    sel[k] = 1'b1; pen[k] = 1'b0; wr[k] = w; addr[k] = a; prot[k] = p;
    wdata[k] = $urandom; strb[k] = 4'($urandom);
    clear_exp(k);
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int j = 1; j <= nacc; j++) begin
      if (abort_at >= 0 && j > abort_at) begin
        sel[k] = 1'b0; pen[k] = 1'b0;
        clear_exp(k);
        @(negedge clk);
        @(posedge clk);
        #1;
        return;
      end
      pen[k]  = 1'b1;
      addr[k] = $urandom; wr[k] = 1'($urandom); prot[k] = 3'($urandom);
      wdata[k] = $urandom; strb[k] = 4'($urandom);
      if (j == nacc) begin
        wdata[k] = wd;
        strb[k]  = st;
      end
      exp_ready[k] = (j == nacc);
      exp_err[k]   = (j == nacc) && e;
      exp_rdata[k] = (j == nacc && !w && !e) ? mem[k][idx] : 32'h0;
      @(negedge clk);
      if (lat == 0 && ready[k]) lat = j;
      if (j == nacc) begin
        rd = rdata[k];
        er = serr[k];
      end
      @(posedge clk);
      if (j == nacc && w && !e) begin
        for (int b = 0; b < NB; b++) begin
          if (st[b]) mem[k][idx][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
      #1;
    end
    sel[k] = 1'b0; pen[k] = 1'b0;
    clear_exp(k);
  endtask

  task automatic wr_reg(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, input logic [2:0] p, output bit er);
    logic [31:0] rd;
    int lat;
    xfer(k, 1'b1, a, d, st, p, -1, rd, er, lat);
  endtask

  task automatic rd_reg(input int k, input logic [31:0] a, output logic [31:0] rd, output bit er);
    int lat;
    xfer(k, 1'b0, a, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    int lat;
    int k;
    bit w;
    logic [31:0] a;
    logic [2:0] p;
    int ab;

    rstn = 1'b0;
    sel = '0; pen = '0; wr = '0; addr = '0; wdata = '0; strb = '0; prot = '0;
    clear_exp(0);
    clear_exp(1);
    for (int kk = 0; kk < 2; kk++)
      for (int i = 0; i < RN; i++) mem[kk][i] = '0;
    @(posedge clk);
    #2;
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_slverr", 32'(serr), 32'h0);
    check("reset_rdata0", rdata[0], 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, -1, rd, er, lat);
    check("w0_latency", 32'(lat), 32'd1);
    check("w0_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    check("r0_latency", 32'(lat), 32'd1);
    check("r0_data", rd, 32'hDEADBEEF);
    check("r0_err", 32'(er), 32'd0);

    wr_reg(0, 32'h8, 32'h11223344, 4'hF, 3'b000, er);
    wr_reg(0, 32'h8, 32'hAABBCCDD, 4'b0101, 3'b000, er);
    rd_reg(0, 32'h8, rd, er);
    check("strobe_merge", rd, 32'h11BB33DD);

    idle(2);
    rd_reg(0, 32'h40, rd, er);
    check("oob_err", 32'(er), 32'd1);
    check("oob_rdata", rd, 32'h0);
    wr_reg(0, 32'h6, 32'h55555555, 4'hF, 3'b000, er);
    check("unaligned_err", 32'(er), 32'd1);
    rd_reg(0, 32'h4, rd, er);
    check("unaligned_nowrite", rd, 32'hDEADBEEF);
    wr_reg(0, 32'h0, 32'h12345678, 4'hF, 3'b000, er);
    check("priv_err", 32'(er), 32'd1);
    rd_reg(0, 32'h0, rd, er);
    check("priv_nowrite", rd, 32'h0);
    wr_reg(0, 32'h0, 32'h12345678, 4'hF, 3'b001, er);
    check("priv_ok", 32'(er), 32'd0);
    rd_reg(0, 32'h0, rd, er);
    check("priv_data", rd, 32'h12345678);

    idle(1);
    xfer(1, 1'b1, 32'h104, 32'hA5A5F00F, 4'hF, 3'b000, -1, rd, er, lat);
    check("w1_latency", 32'(lat), 32'd4);
    xfer(1, 1'b0, 32'h104, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    check("b2b_latency_a", 32'(lat), 32'd4);
    check("b2b_data", rd, 32'hA5A5F00F);
    xfer(1, 1'b0, 32'h108, 32'h0, 4'h0, 3'b000, -1, rd, er, lat);
    check("b2b_latency_b", 32'(lat), 32'd4);
    rd_reg(1, 32'hFC, rd, er);
    check("below_base_err", 32'(er), 32'd1);
    rd_reg(1, 32'h140, rd, er);
    check("last_plus1_err", 32'(er), 32'd1);
    rd_reg(1, 32'h13C, rd, er);
    check("last_reg_ok", 32'(er), 32'd0);

    xfer(1, 1'b1, 32'h10C, 32'h77777777, 4'hF, 3'b000, 1, rd, er, lat);
    idle(1);
    rd_reg(1, 32'h10C, rd, er);
    check("abort_nowrite", rd, 32'h0);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 1);
      w = 1'($urandom);
      p = 3'($urandom);
      case ($urandom_range(0, 9))
        0:       a = base_of(k) + 32'($urandom_range(0, 80));
        1:       a = $urandom;
        2:       a = base_of(k) - 32'd4;
        default: a = base_of(k) + 32'(4 * $urandom_range(0, RN - 1));
      endcase
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, wait_of(k)) : -1;
      xfer(k, w, a, $urandom, 4'($urandom), p, ab, rd, er, lat);
      idle($urandom_range(0, 2));
    end

    wr_reg(0, 32'h8, 32'hCAFEF00D, 4'hF, 3'b000, er);
    sel[0] = 1'b1; pen[0] = 1'b0; wr[0] = 1'b0; addr[0] = 32'h8; prot[0] = 3'b000;
    clear_exp(0);
    @(negedge clk);
    @(posedge clk);
    #1;
    pen[0] = 1'b1;
    exp_ready[0] = 1'b1;
    exp_rdata[0] = mem[0][2];
    #2;
    check("pre_reset_ready", 32'(ready[0]), 32'd1);
    check("pre_reset_rdata", rdata[0], 32'hCAFEF00D);
    rstn = 1'b0;
    clear_exp(0);
    clear_exp(1);
    for (int kk = 0; kk < 2; kk++)
      for (int i = 0; i < RN; i++) mem[kk][i] = '0;
    #1;
    check("async_rst_ready", 32'(ready[0]), 32'd0);
    check("async_rst_slverr", 32'(serr[0]), 32'd0);
    check("async_rst_rdata", rdata[0], 32'h0);
    sel = '0; pen = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int kk = 0; kk < 2; kk++) begin
      for (int i = 0; i < RN; i++) begin
        rd_reg(kk, base_of(kk) + 32'(4 * i), rd, er);
        check($sformatf("post_reset_reg%0d_%0d", kk, i), rd, 32'h0);
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
